gf_inv_seq: RTL and testbench



---
 rtl/gf_pkg.sv | 17 +
 rtl/gf_inv_seq_if.sv | 34 +++
 rtl/gf_mult_poly.sv | 31 +++
 rtl/gf_inv_seq.sv | 120 ++++++++++++
 tb/tb_gf_inv_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^13) constants, element type and inverter state encoding
// for the BCH decoder datapath.
package gf_pkg;

    localparam int unsigned      GF_M    = 13;
    localparam logic [GF_M-1:0]  GF_POLY = 13'h001B;

    typedef logic [GF_M-1:0] gf_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/gf_inv_seq_if.sv
// Operand/result valid-ready bundle of the sequential GF(2^M) inverter.
interface gf_inv_seq_if #(
    parameter int unsigned M = gf_pkg::GF_M
);

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_inv;
    logic         out_err;

    modport master (
        output in_valid,
        output in_a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inv,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inv,
        output out_err
    );

endinterface

// File: rtl/gf_mult_poly.sv
// Combinational polynomial-basis GF(2^M) multiplier: MSB-first
// shift-and-xor, reducing each shift by the low bits of p(x).
module gf_mult_poly
    import gf_pkg::*;
#(
    parameter int unsigned  M    = GF_M,
    parameter logic [M-1:0] POLY = GF_POLY
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic [M-1:0] p_o
);

    logic [M-1:0] acc;
    logic [M-1:0] bsh;

    always_comb begin
        acc = '0;
        bsh = b_i;
        for (int unsigned i = 0; i < M; i++) begin
            // Horner step: acc = acc*x mod p(x), then add a if this b bit is set.
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0);
            if (bsh[M-1]) begin
                acc = acc ^ a_i;
            end
            bsh = bsh << 1;
        end
        p_o = acc;
    end

endmodule

// File: rtl/gf_inv_seq.sv
// Sequential GF(2^M) inverter, a^-1 = a^(2^M-2), one shared multiplier op per cycle.
// Optional zero-operand shortcut with error flag: define GF_INV_ZERO_CHK_EN.
module gf_inv_seq
    import gf_pkg::*;
#(
    parameter int unsigned  M    = GF_M,
    parameter logic [M-1:0] POLY = GF_POLY
) (
    input  logic        clk,
    input  logic        rst,
    gf_inv_seq_if.slave bus
);

    localparam int unsigned   CW       = $clog2(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 2);

    state_t        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q;
    logic          accept;
    logic [M-1:0]  mul_b;
    logic [M-1:0]  mul_p;

    // Squaring multiplies r by itself; MUL steps multiply r by the latched operand.
    assign mul_b  = (state_q == MUL) ? a_q : r_q;
    assign accept = bus.in_valid & rdy_q;

    gf_mult_poly #(
        .M    (M),
        .POLY (POLY)
    ) u_mult (
        .a_i (r_q),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    r_d     = bus.in_a;
                    cnt_d   = '0;
                    state_d = SQR;
`ifdef GF_INV_ZERO_CHK_EN
                    if (bus.in_a == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            SQR: begin
                r_d     = mul_p;
                state_d = (cnt_q == CNT_LAST) ? DONE : MUL;
            end
            MUL: begin
                r_d     = mul_p;
                cnt_d   = cnt_q + 1'b1;
                state_d = SQR;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == IDLE);
        end
    end

`ifdef GF_INV_ZERO_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = (bus.in_a == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_inv   = (state_q == DONE) ? r_q : '0;

endmodule

// File: tb/tb_gf_inv_seq.sv
// Self-checking bench for gf_inv_seq: randomized operands checked against a
// carry-less-product reference multiplier; honours GF_INV_ZERO_CHK_EN.
module tb_gf_inv_seq;

    localparam int LAT_FULL = 23;
    localparam int SPAN     = 24;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations recorded by do_op for the calling test to compare.
    logic [12:0] o_inv;
    logic        o_err;
    int          o_lat;
    bit          o_to;
    bit          o_rdy_busy;
    bit          o_unstable;
    logic        o_hs_valid;
    int          acc_cyc;
    int          hs_cyc;

    gf_inv_seq_if #(.M(13)) bus ();

    gf_inv_seq #(
        .M    (13),
        .POLY (13'h001B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Full product up to degree 24, then reduce by p(x) = x^13+x^4+x^3+x+1.
    function automatic logic [12:0] ref_mul(input logic [12:0] a, input logic [12:0] b);
        logic [24:0] prod;
        prod = '0;
        for (int i = 0; i < 13; i++) begin
            if (((a >> i) & 13'd1) != 13'd0) prod = prod ^ (25'(b) << i);
        end
        for (int k = 24; k >= 13; k--) begin
            if (((prod >> k) & 25'd1) != 25'd0) prod = prod ^ (25'(14'h201B) << (k - 13));
        end
        return prod[12:0];
    endfunction

    function automatic int exp_lat(input logic [12:0] a);
`ifdef GF_INV_ZERO_CHK_EN
        if (a == 13'd0) return 0;
`endif
        return LAT_FULL;
    endfunction

    function automatic logic exp_err(input logic [12:0] a);
`ifdef GF_INV_ZERO_CHK_EN
        return (a == 13'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input logic [12:0] a, input int stall, input bit keep, input logic [12:0] nxt);
        int n;
        o_to = 0; o_rdy_busy = 0; o_unstable = 0; o_lat = -1;
        o_inv = 'x; o_err = 'x; o_hs_valid = 'x;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.out_ready = (stall == 0);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (bus.in_ready !== 1'b1) begin
            o_to = 1; bus.in_valid = 1'b0; return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = keep;
        bus.in_a     = keep ? nxt : 13'($urandom);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            if (bus.in_ready !== 1'b0) o_rdy_busy = 1;
            @(posedge clk); #1; n++;
        end
        if (bus.out_valid !== 1'b1) begin
            o_to = 1; return;
        end
        o_lat = n;
        o_inv = bus.out_inv;
        o_err = bus.out_err;
        if (bus.in_ready !== 1'b0) o_rdy_busy = 1;
        for (int s = 0; s < stall; s++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_inv !== o_inv || bus.out_err !== o_err) o_unstable = 1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        hs_cyc     = cyc;
        o_hs_valid = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inv !== 13'h0) begin n_bad++; $display("FAIL reset_out_inv: got %h want 0000", bus.out_inv); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_one();
        do_op(13'h0001, 0, 0, 13'h0);
        n_cmp++; if (o_to !== 1'b0) begin n_bad++; $display("FAIL one_timeout: got %b want 0", o_to); end
        n_cmp++; if (o_inv !== 13'h0001) begin n_bad++; $display("FAIL one_inv: got %h want 0001", o_inv); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL one_err: got %b want 0", o_err); end
        n_cmp++; if (o_lat !== LAT_FULL) begin n_bad++; $display("FAIL one_latency: got %0d want %0d", o_lat, LAT_FULL); end
        n_cmp++; if (o_hs_valid !== 1'b0) begin n_bad++; $display("FAIL one_valid_after_hs: got %b want 0", o_hs_valid); end
    endtask

    task automatic test_x();
        do_op(13'h0002, 0, 0, 13'h0);
        n_cmp++; if (o_inv !== 13'h100D) begin n_bad++; $display("FAIL x_inv: got %h want 100d", o_inv); end
        n_cmp++; if (o_rdy_busy !== 1'b0) begin n_bad++; $display("FAIL x_ready_busy: got %b want 0", o_rdy_busy); end
        n_cmp++; if (hs_cyc - acc_cyc !== SPAN) begin n_bad++; $display("FAIL x_span: got %0d want %0d", hs_cyc - acc_cyc, SPAN); end
    endtask

    task automatic test_zero();
        do_op(13'h0000, 0, 0, 13'h0);
        n_cmp++; if (o_to !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: got %b want 0", o_to); end
        n_cmp++; if (o_inv !== 13'h0000) begin n_bad++; $display("FAIL zero_inv: got %h want 0000", o_inv); end
        n_cmp++; if (o_err !== exp_err(13'h0)) begin n_bad++; $display("FAIL zero_err: got %b want %b", o_err, exp_err(13'h0)); end
        n_cmp++; if (o_lat !== exp_lat(13'h0)) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", o_lat, exp_lat(13'h0)); end
        // A following nonzero accept must clear the flag.
        do_op(13'h0003, 0, 0, 13'h0);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL zero_err_clear: got %b want 0", o_err); end
        n_cmp++; if (ref_mul(13'h0003, o_inv) !== 13'h0001) begin n_bad++; $display("FAIL zero_next_prod: got %h want 0001", ref_mul(13'h0003, o_inv)); end
    endtask

    task automatic test_random();
        logic [12:0] a;
        int stall;
        for (int i = 0; i < 300; i++) begin
            if (i == 0)      a = 13'h1FFF;
            else if (i == 1) a = 13'h1000;
            else             a = 13'($urandom_range(1, 8191));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(a, stall, 0, 13'h0);
            n_cmp++; if (o_to !== 1'b0) begin n_bad++; $display("FAIL rand_timeout: a=%h got %b want 0", a, o_to); end
            n_cmp++; if (ref_mul(a, o_inv) !== 13'h0001) begin n_bad++; $display("FAIL rand_prod: a=%h inv=%h got %h want 0001", a, o_inv, ref_mul(a, o_inv)); end
            n_cmp++; if (o_lat !== LAT_FULL) begin n_bad++; $display("FAIL rand_latency: a=%h got %0d want %0d", a, o_lat, LAT_FULL); end
            n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL rand_err: a=%h got %b want 0", a, o_err); end
            n_cmp++; if (hs_cyc - acc_cyc !== SPAN + stall) begin n_bad++; $display("FAIL rand_span: a=%h got %0d want %0d", a, hs_cyc - acc_cyc, SPAN + stall); end
            n_cmp++; if (o_unstable !== 1'b0) begin n_bad++; $display("FAIL rand_hold: a=%h got %b want 0", a, o_unstable); end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] a;
        int prev_hs;
        prev_hs = -1;
        for (int i = 0; i < 20; i++) begin
            a = 13'($urandom_range(1, 8191));
            do_op(a, 0, 0, 13'h0);
            n_cmp++; if (ref_mul(a, o_inv) !== 13'h0001) begin n_bad++; $display("FAIL b2b_prod: a=%h got %h want 0001", a, ref_mul(a, o_inv)); end
            n_cmp++; if (hs_cyc - acc_cyc !== SPAN) begin n_bad++; $display("FAIL b2b_span: got %0d want %0d", hs_cyc - acc_cyc, SPAN); end
            if (prev_hs >= 0) begin
                n_cmp++; if (acc_cyc - prev_hs !== 1) begin n_bad++; $display("FAIL b2b_gap: got %0d want 1", acc_cyc - prev_hs); end
            end
            prev_hs = hs_cyc;
        end
    endtask

    task automatic test_stall();
        logic [12:0] a;
        int prev_hs;
        a = 13'($urandom_range(1, 8191));
        do_op(a, 10, 1, 13'h1FFF);
        prev_hs = hs_cyc;
        n_cmp++; if (o_unstable !== 1'b0) begin n_bad++; $display("FAIL stall_hold: got %b want 0", o_unstable); end
        n_cmp++; if (o_rdy_busy !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", o_rdy_busy); end
        n_cmp++; if (ref_mul(a, o_inv) !== 13'h0001) begin n_bad++; $display("FAIL stall_prod: a=%h got %h want 0001", a, ref_mul(a, o_inv)); end
        n_cmp++; if (hs_cyc - acc_cyc !== SPAN + 10) begin n_bad++; $display("FAIL stall_span: got %0d want %0d", hs_cyc - acc_cyc, SPAN + 10); end
        do_op(13'h1FFF, 0, 0, 13'h0);
        n_cmp++; if (acc_cyc - prev_hs !== 1) begin n_bad++; $display("FAIL stall_next_accept: got %0d want 1", acc_cyc - prev_hs); end
        n_cmp++; if (ref_mul(13'h1FFF, o_inv) !== 13'h0001) begin n_bad++; $display("FAIL stall_next_prod: got %h want 0001", ref_mul(13'h1FFF, o_inv)); end
    endtask

    task automatic test_rst_mid();
        bit seen_valid;
        int n;
        bus.in_valid = 1'b1; bus.in_a = 13'h0ABC; bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_accept: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inv !== 13'h0) begin n_bad++; $display("FAIL rst_mid_out_inv: got %h want 0000", bus.out_inv); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_err: got %b want 0", bus.out_err); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen_valid = 1;
        end
        n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_valid: got %b want 0", seen_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready_after: got %b want 1", bus.in_ready); end
        do_op(13'h0002, 0, 0, 13'h0);
        n_cmp++; if (o_inv !== 13'h100D) begin n_bad++; $display("FAIL rst_mid_next_inv: got %h want 100d", o_inv); end
    endtask

    initial begin
        test_reset();
        test_one();
        test_x();
        test_zero();
        test_random();
        test_back_to_back();
        test_stall();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want completion before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
